// File: rtl/decode_ctrl_queue_pkg.sv
// Shared types for the decode queue: control word, mux selects, ALU/compare ops, opcodes, immediate formats.
package decode_ctrl_queue_pkg;

   typedef enum logic [2:0] {
      ALU_ADD = 3'd0, ALU_SLL = 3'd1, ALU_SRA = 3'd2, ALU_SUB = 3'd3,
      ALU_XOR = 3'd4, ALU_SRL = 3'd5, ALU_OR  = 3'd6, ALU_AND = 3'd7
   } alu_ops_t;

   typedef enum logic [2:0] {
      CMP_BEQ = 3'd0, CMP_BNE = 3'd1, CMP_BLT = 3'd4,
      CMP_BGE = 3'd5, CMP_BLTU = 3'd6, CMP_BGEU = 3'd7
   } branch_funct3_t;

   typedef enum logic [0:0] {AM1_RS1_OUT = 1'b0, AM1_PC_OUT = 1'b1} alumux1_t;

   typedef enum logic [2:0] {
      AM2_I_IMM = 3'd0, AM2_U_IMM = 3'd1, AM2_B_IMM = 3'd2,
      AM2_S_IMM = 3'd3, AM2_J_IMM = 3'd4, AM2_RS2_OUT = 3'd5
   } alumux2_t;

   typedef enum logic [0:0] {CMPMUX_RS2_OUT = 1'b0, CMPMUX_I_IMM = 1'b1} cmpmux_t;

   typedef enum logic [2:0] {
      RF_ALU_OUT = 3'd0, RF_BR_EN = 3'd1, RF_U_IMM = 3'd2,
      RF_MDR = 3'd3, RF_PC_PLUS4 = 3'd4, RF_MULDIV_OUT = 3'd5
   } regfilemux_t;

   typedef enum logic [6:0] {
      OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111,
      OP_JALR = 7'b1100111, OP_BR = 7'b1100011, OP_LOAD = 7'b0000011,
      OP_STORE = 7'b0100011, OP_IMM = 7'b0010011, OP_REG = 7'b0110011
   } opcode_t;

   typedef enum logic [2:0] {FMT_NONE, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} imm_fmt_t;

   typedef struct packed {
      logic           regfile_ld;
      alumux1_t       alumux1;
      alumux2_t       alumux2;
      cmpmux_t        cmpmux;
      regfilemux_t    regfilemux;
      logic           dcache_read;
      logic           dcache_write;
      alu_ops_t       aluop;
      branch_funct3_t cmpop;
      logic           muldiv_en;
      logic [2:0]     muldiv_op;
   } ctrl_word_t;

   // Every field's zero encoding is the default selection, so an all-zero word is the default word.
   localparam ctrl_word_t CTRL_DEFAULT = '{
      regfile_ld: 1'b0, alumux1: AM1_RS1_OUT, alumux2: AM2_I_IMM, cmpmux: CMPMUX_RS2_OUT,
      regfilemux: RF_ALU_OUT, dcache_read: 1'b0, dcache_write: 1'b0, aluop: ALU_ADD,
      cmpop: CMP_BEQ, muldiv_en: 1'b0, muldiv_op: 3'd0
   };

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [6:0] F7_BASE   = 7'h00;
   localparam logic [6:0] F7_ALT    = 7'h20;
   localparam logic [6:0] F7_MULDIV = 7'h01;

endpackage

// File: rtl/decode_ctrl_queue_if.sv
// Fetch-side and execute-side handshake bundle of the decode queue.
interface decode_ctrl_queue_if import decode_ctrl_queue_pkg::*; #(parameter int XLEN = 32) ();
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_instr;
   logic [XLEN-1:0] in_pc;
   logic            flush;
   logic            out_valid;
   logic            out_ready;
   ctrl_word_t      out_ctrl;
   logic [XLEN-1:0] out_pc;
   logic [4:0]      out_rs1;
   logic [4:0]      out_rs2;
   logic [4:0]      out_rd;
   logic [XLEN-1:0] out_imm;
   logic            out_illegal;

   modport master (
      output in_valid, in_instr, in_pc, flush, out_ready,
      input  in_ready, out_valid, out_ctrl, out_pc, out_rs1, out_rs2, out_rd, out_imm, out_illegal
   );
   modport slave (
      input  in_valid, in_instr, in_pc, flush, out_ready,
      output in_ready, out_valid, out_ctrl, out_pc, out_rs1, out_rs2, out_rd, out_imm, out_illegal
   );
endinterface

// File: rtl/decode_ctrl_queue_rom.sv
// Combinational RV32I instruction decoder (module decode_ctrl_rom).
// Define DECODE_RV32M_EN to decode the RV32M multiply/divide group.
module decode_ctrl_rom import decode_ctrl_queue_pkg::*; #(parameter int XLEN = 32) (
   input  logic [31:0]     instr,
   output ctrl_word_t      ctrl,
   output logic [4:0]      rs1,
   output logic [4:0]      rs2,
   output logic [4:0]      rd,
   output logic [XLEN-1:0] imm,
   output logic            illegal
);
   logic [2:0]         funct3_s;
   logic [6:0]         funct7_s;
   imm_fmt_t           fmt_s;
   logic signed [31:0] imm32_s;

   assign funct3_s = instr[14:12];
   assign funct7_s = instr[31:25];
   assign rs1      = instr[19:15];
   assign rs2      = instr[24:20];
   assign rd       = instr[11:7];

   // Control word and immediate format from opcode/funct fields
   always_comb begin
      ctrl    = CTRL_DEFAULT;
      illegal = 1'b0;
      fmt_s   = FMT_NONE;
      case (opcode_t'(instr[6:0]))
         OP_LUI: begin
            ctrl.regfile_ld = 1'b1; ctrl.regfilemux = RF_U_IMM; fmt_s = FMT_U;
         end
         OP_AUIPC: begin
            ctrl.alumux1 = AM1_PC_OUT; ctrl.alumux2 = AM2_U_IMM; ctrl.regfile_ld = 1'b1; fmt_s = FMT_U;
         end
         OP_JAL: begin
            ctrl.alumux1 = AM1_PC_OUT; ctrl.alumux2 = AM2_J_IMM;
            ctrl.regfilemux = RF_PC_PLUS4; ctrl.regfile_ld = 1'b1; fmt_s = FMT_J;
         end
         OP_JALR: begin
            ctrl.regfilemux = RF_PC_PLUS4; ctrl.regfile_ld = 1'b1; fmt_s = FMT_I;
         end
         OP_BR: begin
            ctrl.alumux1 = AM1_PC_OUT; ctrl.alumux2 = AM2_B_IMM;
            ctrl.cmpop = branch_funct3_t'(funct3_s); fmt_s = FMT_B;
         end
         OP_LOAD: begin
            ctrl.dcache_read = 1'b1; ctrl.regfilemux = RF_MDR; ctrl.regfile_ld = 1'b1; fmt_s = FMT_I;
         end
         OP_STORE: begin
            ctrl.dcache_write = 1'b1; ctrl.alumux2 = AM2_S_IMM; fmt_s = FMT_S;
         end
         OP_IMM: begin
            ctrl.aluop = alu_ops_t'(funct3_s); ctrl.regfile_ld = 1'b1; fmt_s = FMT_I;
            case (funct3_s)
               F3_SLT:  begin ctrl.cmpop = CMP_BLT;  ctrl.cmpmux = CMPMUX_I_IMM; ctrl.regfilemux = RF_BR_EN; end
               F3_SLTU: begin ctrl.cmpop = CMP_BLTU; ctrl.cmpmux = CMPMUX_I_IMM; ctrl.regfilemux = RF_BR_EN; end
               F3_SR:   ctrl.aluop = funct7_s[5] ? ALU_SRA : ALU_SRL;
               default: ctrl.aluop = alu_ops_t'(funct3_s);
            endcase
         end
         OP_REG: begin
            if ((funct7_s == F7_BASE) || (funct7_s == F7_ALT)) begin
               ctrl.alumux2 = AM2_RS2_OUT; ctrl.regfile_ld = 1'b1; ctrl.aluop = alu_ops_t'(funct3_s);
               case (funct3_s)
                  F3_ADD:  ctrl.aluop = funct7_s[5] ? ALU_SUB : ALU_ADD;
                  F3_SLT:  begin ctrl.cmpop = CMP_BLT;  ctrl.cmpmux = CMPMUX_RS2_OUT; ctrl.regfilemux = RF_BR_EN; end
                  F3_SLTU: begin ctrl.cmpop = CMP_BLTU; ctrl.cmpmux = CMPMUX_RS2_OUT; ctrl.regfilemux = RF_BR_EN; end
                  F3_SR:   ctrl.aluop = funct7_s[5] ? ALU_SRA : ALU_SRL;
                  default: ctrl.aluop = alu_ops_t'(funct3_s);
               endcase
            end else if (funct7_s == F7_MULDIV) begin
`ifdef DECODE_RV32M_EN
               ctrl.muldiv_en = 1'b1; ctrl.muldiv_op = funct3_s;
               ctrl.regfile_ld = 1'b1; ctrl.regfilemux = RF_MULDIV_OUT;
`else
               illegal = 1'b1;
`endif
            end else begin
               illegal = 1'b1;
            end
         end
         default: illegal = 1'b1;
      endcase
      // Writes to x0 are architecturally discarded, so never request them.
      ctrl.regfile_ld = ctrl.regfile_ld & (rd != 5'd0);
   end

   // Immediate assembly per format
   always_comb begin
      case (fmt_s)
         FMT_I:   imm32_s = {{21{instr[31]}}, instr[30:20]};
         FMT_S:   imm32_s = {{21{instr[31]}}, instr[30:25], instr[11:7]};
         FMT_B:   imm32_s = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
         FMT_U:   imm32_s = {instr[31:12], 12'h000};
         FMT_J:   imm32_s = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
         default: imm32_s = 32'sd0;
      endcase
   end

   assign imm = XLEN'(imm32_s);
endmodule

// File: rtl/decode_ctrl_queue.sv
// Decode stage: decodes at enqueue and buffers decoded entries in a DEPTH-entry FIFO.
// DECODE_RV32M_EN (see decode_ctrl_rom) enables RV32M decode.
module decode_ctrl_queue import decode_ctrl_queue_pkg::*; #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 2
) (
   input  logic                clk,
   input  logic                rst,
   decode_ctrl_queue_if.slave  bus
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   typedef struct packed {
      ctrl_word_t      ctrl;
      logic [XLEN-1:0] pc;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic [XLEN-1:0] imm;
      logic            illegal;
   } entry_t;

   entry_t           mem_r [DEPTH];
   entry_t           dec_s;
   entry_t           head_s;
   logic [PTR_W-1:0] head_r;
   logic [PTR_W-1:0] tail_r;
   logic [CNT_W-1:0] count_r;
   logic             push_s;
   logic             pop_s;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : p + PTR_W'(1);
   endfunction

   decode_ctrl_rom #(.XLEN(XLEN)) u_rom (
      .instr   (bus.in_instr),
      .ctrl    (dec_s.ctrl),
      .rs1     (dec_s.rs1),
      .rs2     (dec_s.rs2),
      .rd      (dec_s.rd),
      .imm     (dec_s.imm),
      .illegal (dec_s.illegal)
   );
   assign dec_s.pc = bus.in_pc;

   // in_ready depends only on occupancy, never on out_ready.
   assign bus.in_ready  = (count_r < CNT_W'(DEPTH));
   assign bus.out_valid = (count_r != {CNT_W{1'b0}});
   assign push_s = bus.in_valid & bus.in_ready & ~bus.flush;
   assign pop_s  = bus.out_valid & bus.out_ready & ~bus.flush;

   // Storage, pointers and occupancy; flush empties the queue but leaves stale slot data
   always_ff @(posedge clk) begin
      if (rst) begin
         head_r  <= {PTR_W{1'b0}};
         tail_r  <= {PTR_W{1'b0}};
         count_r <= {CNT_W{1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
      end else if (bus.flush) begin
         head_r  <= {PTR_W{1'b0}};
         tail_r  <= {PTR_W{1'b0}};
         count_r <= {CNT_W{1'b0}};
      end else begin
         if (push_s) begin
            mem_r[tail_r] <= dec_s;
            tail_r        <= next_ptr(tail_r);
         end
         if (pop_s) begin
            head_r <= next_ptr(head_r);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Head entry, zeroed while empty so stale slots never leak out
   always_comb begin
      if (bus.out_valid) begin
         head_s = mem_r[head_r];
      end else begin
         head_s = '0;
      end
   end

   assign bus.out_ctrl    = head_s.ctrl;
   assign bus.out_pc      = head_s.pc;
   assign bus.out_rs1     = head_s.rs1;
   assign bus.out_rs2     = head_s.rs2;
   assign bus.out_rd      = head_s.rd;
   assign bus.out_imm     = head_s.imm;
   assign bus.out_illegal = head_s.illegal;
endmodule

// File: tb/tb_decode_ctrl_queue.sv
// Scoreboard bench for decode_ctrl_queue: directed cases followed by random traffic against a reference decoder.
module tb_decode_ctrl_queue;
   import decode_ctrl_queue_pkg::*;

   localparam int DEPTH = 2;

   typedef struct {
      ctrl_word_t  ctrl;
      logic [31:0] pc;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] imm;
      logic        illegal;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   bit   mon_en = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;
   exp_t exp_q[$];
   logic [31:0] pc_v = 32'h0000_0200;

   decode_ctrl_queue_if #(.XLEN(32)) bus ();

   decode_ctrl_queue #(.XLEN(32), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference decoder built from the instruction-set rules with shifts and masks.
   function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc);
      exp_t e;
      logic [6:0] op;
      logic [2:0] f3;
      logic [6:0] f7;
      logic signed [31:0] s, sh20, sh19, sh11;
      op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
      s = ins; sh20 = s >>> 20; sh19 = s >>> 19; sh11 = s >>> 11;
      e.ctrl = '0; e.imm = 32'd0; e.illegal = 1'b0; e.pc = pc;
      e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7];
      if (op == 7'h37) begin
         e.ctrl.regfile_ld = 1'b1; e.ctrl.regfilemux = RF_U_IMM; e.imm = ins & 32'hFFFF_F000;
      end else if (op == 7'h17) begin
         e.ctrl.alumux1 = AM1_PC_OUT; e.ctrl.alumux2 = AM2_U_IMM; e.ctrl.regfile_ld = 1'b1;
         e.imm = ins & 32'hFFFF_F000;
      end else if (op == 7'h6F) begin
         e.ctrl.alumux1 = AM1_PC_OUT; e.ctrl.alumux2 = AM2_J_IMM; e.ctrl.regfilemux = RF_PC_PLUS4;
         e.ctrl.regfile_ld = 1'b1;
         e.imm = (sh11 & 32'hFFF0_0000) | (ins & 32'h000F_F000) | ((ins >> 9) & 32'h800) | ((ins >> 20) & 32'h7FE);
      end else if (op == 7'h67) begin
         e.ctrl.regfilemux = RF_PC_PLUS4; e.ctrl.regfile_ld = 1'b1; e.imm = sh20;
      end else if (op == 7'h63) begin
         e.ctrl.alumux1 = AM1_PC_OUT; e.ctrl.alumux2 = AM2_B_IMM; e.ctrl.cmpop = branch_funct3_t'(f3);
         e.imm = (sh19 & 32'hFFFF_F000) | ((ins << 4) & 32'h800) | ((ins >> 20) & 32'h7E0) | ((ins >> 7) & 32'h1E);
      end else if (op == 7'h03) begin
         e.ctrl.dcache_read = 1'b1; e.ctrl.regfilemux = RF_MDR; e.ctrl.regfile_ld = 1'b1; e.imm = sh20;
      end else if (op == 7'h23) begin
         e.ctrl.dcache_write = 1'b1; e.ctrl.alumux2 = AM2_S_IMM;
         e.imm = (sh20 & ~32'h1F) | ((ins >> 7) & 32'h1F);
      end else if (op == 7'h13) begin
         e.ctrl.regfile_ld = 1'b1; e.imm = sh20;
         e.ctrl.aluop = (f3 == 3'd5) ? (ins[30] ? ALU_SRA : ALU_SRL) : alu_ops_t'(f3);
         if (f3 == 3'd2 || f3 == 3'd3) begin
            e.ctrl.cmpop = (f3 == 3'd2) ? CMP_BLT : CMP_BLTU;
            e.ctrl.cmpmux = CMPMUX_I_IMM; e.ctrl.regfilemux = RF_BR_EN;
         end
      end else if (op == 7'h33 && (f7 == 7'h00 || f7 == 7'h20)) begin
         e.ctrl.alumux2 = AM2_RS2_OUT; e.ctrl.regfile_ld = 1'b1;
         if (f3 == 3'd0)      e.ctrl.aluop = ins[30] ? ALU_SUB : ALU_ADD;
         else if (f3 == 3'd5) e.ctrl.aluop = ins[30] ? ALU_SRA : ALU_SRL;
         else                 e.ctrl.aluop = alu_ops_t'(f3);
         if (f3 == 3'd2 || f3 == 3'd3) begin
            e.ctrl.cmpop = (f3 == 3'd2) ? CMP_BLT : CMP_BLTU;
            e.ctrl.regfilemux = RF_BR_EN;
         end
`ifdef DECODE_RV32M_EN
      end else if (op == 7'h33 && f7 == 7'h01) begin
         e.ctrl.muldiv_en = 1'b1; e.ctrl.muldiv_op = f3;
         e.ctrl.regfile_ld = 1'b1; e.ctrl.regfilemux = RF_MULDIV_OUT;
`endif
      end else begin
         e.illegal = 1'b1;
      end
      if (e.rd == 5'd0) e.ctrl.regfile_ld = 1'b0;
      return e;
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] r;
      r = $urandom();
      case ($urandom_range(0, 11))
         0: r[6:0] = 7'h37;
         1: r[6:0] = 7'h17;
         2: r[6:0] = 7'h6F;
         3: r[6:0] = 7'h67;
         4: r[6:0] = 7'h63;
         5: r[6:0] = 7'h03;
         6: r[6:0] = 7'h23;
         7: r[6:0] = 7'h13;
         8, 9: begin
            r[6:0] = 7'h33;
            case ($urandom_range(0, 3))
               0: r[31:25] = 7'h00;
               1: r[31:25] = 7'h20;
               2: r[31:25] = 7'h01;
               default: r[31:25] = r[31:25];
            endcase
         end
         default: r = r;
      endcase
      return r;
   endfunction

   // Queue-level model: updates the expected contents from what was offered at each edge.
   always @(posedge clk) begin
      int n;
      n = exp_q.size();
      if (rst || bus.flush) begin
         exp_q.delete();
      end else begin
         if (bus.out_ready && n != 0) void'(exp_q.pop_front());
         if (bus.in_valid && n < DEPTH) exp_q.push_back(ref_decode(bus.in_instr, bus.in_pc));
      end
   end

   // Monitor: compares what the DUT presents against the scoreboard head.
   always @(negedge clk) begin
      if (mon_en) begin
         chk("out_valid", 64'(bus.out_valid), 64'(exp_q.size() != 0));
         chk("in_ready", 64'(bus.in_ready), 64'(exp_q.size() < DEPTH));
         if (exp_q.size() != 0) begin
            chk("ctrl", 64'(bus.out_ctrl), 64'(exp_q[0].ctrl));
            chk("pc", 64'(bus.out_pc), 64'(exp_q[0].pc));
            chk("rs1", 64'(bus.out_rs1), 64'(exp_q[0].rs1));
            chk("rs2", 64'(bus.out_rs2), 64'(exp_q[0].rs2));
            chk("rd", 64'(bus.out_rd), 64'(exp_q[0].rd));
            chk("imm", 64'(bus.out_imm), 64'(exp_q[0].imm));
            chk("illegal", 64'(bus.out_illegal), 64'(exp_q[0].illegal));
         end else begin
            chk("empty_ctrl", 64'(bus.out_ctrl), 64'd0);
            chk("empty_pc", 64'(bus.out_pc), 64'd0);
            chk("empty_imm", 64'(bus.out_imm), 64'd0);
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic push1(input logic [31:0] ins);
      bus.in_valid = 1'b1; bus.in_instr = ins; bus.in_pc = pc_v; pc_v = pc_v + 32'd4;
      cyc();
      bus.in_valid = 1'b0;
   endtask

   task automatic pop1();
      bus.out_ready = 1'b1;
      cyc();
      bus.out_ready = 1'b0;
   endtask

   initial begin
      bus.in_valid = 1'b0; bus.in_instr = 32'd0; bus.in_pc = 32'd0;
      bus.flush = 1'b0; bus.out_ready = 1'b0;
      rst = 1'b1;
      cyc(); cyc();
      mon_en = 1'b1;
      @(negedge clk);
      chk("rst_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_ctrl", 64'(bus.out_ctrl), 64'd0);
      chk("rst_ready", 64'(bus.in_ready), 64'd1);
      rst = 1'b0;

      // add x3,x1,x2
      push1(32'h002081B3);
      @(negedge clk);
      chk("add_valid", 64'(bus.out_valid), 64'd1);
      chk("add_aluop", 64'(bus.out_ctrl.aluop), 64'(ALU_ADD));
      chk("add_alumux2", 64'(bus.out_ctrl.alumux2), 64'(AM2_RS2_OUT));
      chk("add_rd", 64'(bus.out_rd), 64'd3);
      chk("add_ld", 64'(bus.out_ctrl.regfile_ld), 64'd1);
      pop1();

      // sub, slt, lw with execute stalled
      bus.in_valid = 1'b1;
      bus.in_instr = 32'h402081B3; bus.in_pc = 32'h104; cyc();
      bus.in_instr = 32'h0020A2B3; bus.in_pc = 32'h108; cyc();
      bus.in_instr = 32'h0080A203; bus.in_pc = 32'h10C;
      @(negedge clk);
      chk("full_ready", 64'(bus.in_ready), 64'd0);
      chk("sub_aluop", 64'(bus.out_ctrl.aluop), 64'(ALU_SUB));
      cyc();
      @(negedge clk);
      chk("third_waits", 64'(bus.in_ready), 64'd0);
      bus.out_ready = 1'b1;
      cyc();
      @(negedge clk);
      chk("slt_cmpmux", 64'(bus.out_ctrl.cmpmux), 64'(CMPMUX_RS2_OUT));
      chk("slt_rfmux", 64'(bus.out_ctrl.regfilemux), 64'(RF_BR_EN));
      cyc();
      @(negedge clk);
      chk("lw_read", 64'(bus.out_ctrl.dcache_read), 64'd1);
      chk("lw_imm", 64'(bus.out_imm), 64'd8);
      chk("lw_rd", 64'(bus.out_rd), 64'd4);
      chk("lw_pc", 64'(bus.out_pc), 64'h10C);
      bus.in_valid = 1'b0;
      cyc();
      @(negedge clk);
      chk("drained", 64'(bus.out_valid), 64'd0);
      bus.out_ready = 1'b0;

      // full queue with both sides active
      bus.in_valid = 1'b1;
      repeat (2) begin bus.in_instr = rand_instr(); bus.in_pc = pc_v; pc_v += 32'd4; cyc(); end
      bus.out_ready = 1'b1;
      repeat (4) begin bus.in_instr = rand_instr(); bus.in_pc = pc_v; pc_v += 32'd4; cyc(); end
      bus.in_valid = 1'b0;
      repeat (3) cyc();
      bus.out_ready = 1'b0;

      // flush with two queued and one incoming
      bus.in_valid = 1'b1;
      repeat (2) begin bus.in_instr = rand_instr(); bus.in_pc = pc_v; pc_v += 32'd4; cyc(); end
      bus.flush = 1'b1; bus.out_ready = 1'b1; bus.in_instr = 32'h002081B3;
      cyc();
      bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
      @(negedge clk);
      chk("flush_empty", 64'(bus.out_valid), 64'd0);
      cyc();
      @(negedge clk);
      chk("flush_no_enq", 64'(bus.out_valid), 64'd0);

      // addi x0 and an unsupported opcode
      push1(32'h00000013);
      @(negedge clk);
      chk("nop_ld", 64'(bus.out_ctrl.regfile_ld), 64'd0);
      chk("nop_illegal", 64'(bus.out_illegal), 64'd0);
      pop1();
      push1(32'h0000007F);
      @(negedge clk);
      chk("bad_illegal", 64'(bus.out_illegal), 64'd1);
      chk("bad_ctrl", 64'(bus.out_ctrl), 64'd0);
      pop1();

      // mul x3,x1,x2
      push1(32'h022081B3);
      @(negedge clk);
`ifdef DECODE_RV32M_EN
      chk("mul_en", 64'(bus.out_ctrl.muldiv_en), 64'd1);
      chk("mul_op", 64'(bus.out_ctrl.muldiv_op), 64'd0);
      chk("mul_illegal", 64'(bus.out_illegal), 64'd0);
`else
      chk("mul_illegal", 64'(bus.out_illegal), 64'd1);
      chk("mul_ctrl", 64'(bus.out_ctrl), 64'd0);
`endif
      pop1();

      // random traffic with occasional flush and reset
      repeat (1500) begin
         bus.in_valid  = ($urandom_range(0, 2) != 0);
         bus.in_instr  = rand_instr();
         bus.in_pc     = $urandom();
         bus.out_ready = ($urandom_range(0, 3) != 0);
         bus.flush     = ($urandom_range(0, 24) == 0);
         rst           = ($urandom_range(0, 299) == 0);
         cyc();
      end
      rst = 1'b0; bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
      repeat (4) cyc();
      @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
